// File: rtl/bram_sp_arbiter_pkg.sv
// bram_sp_arbiter_pkg: shared latency constants for the BRAM arbiter.
// Defining BRAM_ARB_RDREG_EN adds one response register stage (latency 3).
package bram_sp_arbiter_pkg;
    localparam int LAT_BASE = 2;
`ifdef BRAM_ARB_RDREG_EN
    localparam int RSP_LAT = LAT_BASE + 1;
`else
    localparam int RSP_LAT = LAT_BASE;
`endif
endpackage

// File: rtl/bram_sp_arbiter_if.sv
// bram_sp_arbiter_if: requester bus plus BRAM port of the arbiter.
// The slave modport is the arbiter; the master modport is clients plus BRAM.
interface bram_sp_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_wr;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          bram_wr;
    logic [ADDR_WIDTH-1:0]         bram_addr;
    logic [DATA_WIDTH-1:0]         bram_din;
    logic [DATA_WIDTH-1:0]         bram_dout;

    modport slave (
        input  req_valid, req_wr, req_addr, req_data, bram_dout,
        output req_ready, rsp_valid, rsp_data, bram_wr, bram_addr, bram_din
    );
    modport master (
        output req_valid, req_wr, req_addr, req_data, bram_dout,
        input  req_ready, rsp_valid, rsp_data, bram_wr, bram_addr, bram_din
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant starting at a rotating pointer.
// Pointer moves past the granted index whenever a grant is issued.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o
);
    logic [IW-1:0] ptr_q, ptr_d;
    int j;

    // Scan from farthest to nearest so the first valid after the pointer wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr_q) + k) % NUM_REQ;
            if (req_i[j]) begin
                gnt_o = NUM_REQ'(1) << j;
                idx_o = IW'(j);
            end
        end
        if (rst) gnt_o = '0;
        ptr_d = IW'((int'(idx_o) + 1) % NUM_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else if (|gnt_o) ptr_q <= ptr_d;
    end
endmodule

// File: rtl/bram_sp_arbiter.sv
// bram_sp_arbiter: round-robin sharing of one single-port BRAM between NUM_REQ requesters.
// BRAM_ARB_RDREG_EN adds a registered response stage (latency 3 instead of 2).
module bram_sp_arbiter
    import bram_sp_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input logic              clk,
    input logic              rst,
    bram_sp_arbiter_if.slave bus
);
    logic [NUM_REQ-1:0]    gnt;
    logic [IW-1:0]         idx;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [NUM_REQ-1:0]    tag_q [LAT_BASE];
    logic [NUM_REQ-1:0]    tag_out;
    logic [DATA_WIDTH-1:0] rsp_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk   (clk),
        .rst   (rst),
        .req_i (bus.req_valid),
        .gnt_o (gnt),
        .idx_o (idx)
    );

    assign bus.req_ready = gnt;

    always_comb begin
        wr_d   = |gnt & bus.req_wr[idx];
        addr_d = |gnt ? bus.req_addr[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH] : addr_q;
        din_d  = |gnt ? bus.req_data[int'(idx)*DATA_WIDTH +: DATA_WIDTH] : din_q;
    end

    // Tag stage 0 rides with the BRAM op; the last stage lines up with bram_dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            tag_q  <= '{default: '0};
        end else begin
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            tag_q[0] <= gnt;
            for (int k = 1; k < LAT_BASE; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    assign bus.bram_wr   = wr_q;
    assign bus.bram_addr = addr_q;
    assign bus.bram_din  = din_q;
    assign tag_out       = tag_q[LAT_BASE-1];
    assign rsp_d         = |tag_out ? bus.bram_dout : '0;

`ifdef BRAM_ARB_RDREG_EN
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= tag_out;
            rsp_data_q  <= rsp_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
`else
    assign bus.rsp_valid = tag_out;
    assign bus.rsp_data  = rsp_d;
`endif
endmodule

// File: tb/tb_bram_sp_arbiter.sv
// tb_bram_sp_arbiter: directed and random checks of bram_sp_arbiter against a
// transaction-level model (rotating priority, reference memory, timed response queue).
module tb_bram_sp_arbiter;
    import bram_sp_arbiter_pkg::*;
    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_sp_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bram_sp_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // BRAM with registered write-first read port
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (bus.bram_wr) begin
            mem[bus.bram_addr] <= bus.bram_din;
            bus.bram_dout      <= bus.bram_din;
        end else begin
            bus.bram_dout <= mem[bus.bram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int           due;
        logic [N-1:0] who;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          pend[$];
    logic [DW-1:0] ref_mem [16];
    int            mptr = 0;
    int            cyc = 0;
    bit            chk_en = 0;
    logic          exp_wr = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_din = '0;
    int            waitc [N];

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0]  g;
            logic [N-1:0]  ev;
            logic [DW-1:0] ed;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            int            sel;
            cyc++;
            g = '0;
            sel = -1;
            if (!rst)
                for (int k = 0; k < N; k++)
                    if (sel < 0 && bus.req_valid[(mptr + k) % N]) sel = (mptr + k) % N;
            if (sel >= 0) g[sel] = 1'b1;
            chk("req_ready", bus.req_ready, g);
            ev = '0;
            ed = '0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                ev = pend[0].who;
                ed = pend[0].data;
                void'(pend.pop_front());
            end
            chk("rsp_valid", bus.rsp_valid, ev);
            if (ev != '0) chk("rsp_data", bus.rsp_data, ed);
            chk("bram_wr", bus.bram_wr, exp_wr);
            if (exp_wr) begin
                chk("bram_addr", bus.bram_addr, exp_addr);
                chk("bram_din", bus.bram_din, exp_din);
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && !rst) begin
                    waitc[i] = bus.req_ready[i] ? 0 : waitc[i] + 1;
                    chk("starvation", waitc[i] < N, 1);
                end else begin
                    waitc[i] = 0;
                end
            end
            exp_wr = 1'b0;
            if (rst) begin
                pend.delete();
                mptr = 0;
            end else if (sel >= 0) begin
                a = bus.req_addr[sel*AW +: AW];
                d = bus.req_data[sel*DW +: DW];
                if (bus.req_wr[sel]) begin
                    ref_mem[a] = d;
                    exp_wr     = 1'b1;
                    exp_addr   = a;
                    exp_din    = d;
                end else begin
                    d = ref_mem[a];
                end
                pend.push_back('{cyc + RSP_LAT, g, d});
                mptr = (sel + 1) % N;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        bus.req_valid[i]         = v;
        bus.req_wr[i]            = w;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic wait_rsp(input string name, input logic [N-1:0] v, input logic [DW-1:0] d);
        int n = 0;
        while (bus.rsp_valid == '0 && n < 6) begin
            step();
            n++;
        end
        chk({name, "_valid"}, bus.rsp_valid, v);
        chk({name, "_data"}, bus.rsp_data, d);
        step();
    endtask

    initial begin
        logic [N-1:0] acc;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        for (int i = 0; i < N; i++) waitc[i] = 0;
        bus.req_valid = '0;
        bus.req_wr    = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_bram_wr", bus.bram_wr, 0);
        chk("rst_bram_addr", bus.bram_addr, 0);
        chk("rst_bram_din", bus.bram_din, 0);
        step();
        rst = 1'b0;

        // write then read the same address from requester 0
        drive(0, 1, 1, 4'd3, 32'hDEADBEEF);
        #1 chk("t1_grant_wr", bus.req_ready, 2'b01);
        step();
        chk("t1_bram_wr_hi", bus.bram_wr, 1);
        chk("t1_bram_addr", bus.bram_addr, 3);
        drive(0, 1, 0, 4'd3, 32'h0);
        #1 chk("t1_grant_rd", bus.req_ready, 2'b01);
        step();
        chk("t1_bram_wr_lo", bus.bram_wr, 0);
        drive(0, 0, 0, 4'd0, 32'h0);
        wait_rsp("t1_wr", 2'b01, 32'hDEADBEEF);
        wait_rsp("t1_rd", 2'b01, 32'hDEADBEEF);
        repeat (3) step();

        // both requesters continuously valid; pointer is 1 after requester 0's grants
        drive(0, 1, 0, 4'd1, 32'h0);
        drive(1, 1, 0, 4'd2, 32'h0);
        for (int k = 0; k < 8; k++) begin
            #1 chk("t2_alternate", bus.req_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
            step();
        end
        drive(0, 0, 0, 4'd0, 32'h0);
        drive(1, 0, 0, 4'd0, 32'h0);
        repeat (4) step();

        // only requester 1 valid
        drive(1, 1, 0, 4'd5, 32'h0);
        for (int k = 0; k < 5; k++) begin
            #1 chk("t3_req1_only", bus.req_ready, 2'b10);
            step();
        end
        drive(1, 0, 0, 4'd0, 32'h0);
        repeat (4) step();

        // simultaneous write/read of addr 7 with pointer at 0
        drive(0, 1, 1, 4'd7, 32'h55);
        drive(1, 1, 0, 4'd7, 32'h0);
        #1 chk("t4_first", bus.req_ready, 2'b01);
        step();
        drive(0, 0, 0, 4'd0, 32'h0);
        #1 chk("t4_second", bus.req_ready, 2'b10);
        step();
        drive(1, 0, 0, 4'd0, 32'h0);
        wait_rsp("t4_wr", 2'b01, 32'h55);
        wait_rsp("t4_rd", 2'b10, 32'h55);
        repeat (3) step();

        // reset with two reads in flight
        drive(0, 1, 0, 4'd3, 32'h0);
        drive(1, 1, 0, 4'd7, 32'h0);
        step();
        drive(0, 0, 0, 4'd0, 32'h0);
        step();
        drive(1, 0, 0, 4'd0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rsp_valid", bus.rsp_valid, 0);
        chk("t5_rsp_data", bus.rsp_data, 0);
        chk("t5_bram_wr", bus.bram_wr, 0);
        chk("t5_bram_addr", bus.bram_addr, 0);
        chk("t5_bram_din", bus.bram_din, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_no_rsp", bus.rsp_valid, 0);
        end
        drive(0, 1, 0, 4'd1, 32'h0);
        drive(1, 1, 0, 4'd2, 32'h0);
        #1 chk("t5_ptr_zero", bus.req_ready, 2'b01);
        step();
        drive(0, 0, 0, 4'd0, 32'h0);
        step();
        drive(1, 0, 0, 4'd0, 32'h0);
        repeat (4) step();

        // random traffic; ops held until accepted
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++)
                if (!bus.req_valid[i] && $urandom_range(0, 2) != 0)
                    drive(i, 1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
            #1 acc = bus.req_valid & bus.req_ready;
            step();
            for (int i = 0; i < N; i++)
                if (acc[i]) drive(i, 0, 0, 4'd0, 32'h0);
        end
        for (int i = 0; i < N; i++) drive(i, 0, 0, 4'd0, 32'h0);
        repeat (6) step();
        chk("all_responses_seen", pend.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
